// File: rtl/pmem_responder.sv
// pmem_responder: single-port word memory answering the pmem_read/pmem_write
// handshake with a fixed response latency, byte-enable writes and one
// outstanding request.
module pmem_responder #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [31:0] pmem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] pmem_rdata,
  output logic        pmem_resp,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               inr_q, inr_d;
  logic               wr_q, wr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               resp_q, resp_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               req_c;
  logic               accept_c;
  logic [31:0]        offset_c;
  logic               in_range_c;
  logic [IDX_W-1:0]   idx_c;
  logic               unused_bits;

  // Address decode of the live request
  assign req_c      = pmem_read | pmem_write;
  assign accept_c   = (state_q == ST_IDLE) && req_c;
  assign offset_c   = pmem_address - BASE_ADDR;
  assign in_range_c = (pmem_address >= BASE_ADDR) && ((offset_c >> 2) < 32'(DEPTH_WORDS));
  assign idx_c      = offset_c[IDX_W+1:2];
  assign unused_bits = ^{offset_c[1:0], offset_c[31:IDX_W+2]};

  // State and latency counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: counter loaded at accept, RESP reached LATENCY cycles later
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: request latch, read data on RESP entry, flags
  always_comb begin
    logic             rd_kind;
    logic             rd_inr;
    logic [IDX_W-1:0] rd_idx;

    idx_d   = idx_q;
    inr_d   = inr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    resp_d  = (state_d == ST_RESP);
    busy_d  = (state_d != ST_IDLE);

    if (accept_c) begin
      idx_d   = idx_c;
      inr_d   = in_range_c;
      wr_d    = pmem_write;
      wdata_d = pmem_wdata;
      be_d    = mem_byte_enable;
      err_d   = err_q | ~in_range_c | (pmem_read & pmem_write);
    end

    // With LATENCY==1 RESP is entered straight from the accept cycle
    rd_kind = accept_c ? ~pmem_write : ~wr_q;
    rd_inr  = accept_c ? in_range_c  : inr_q;
    rd_idx  = accept_c ? idx_c       : idx_q;
    if ((state_d == ST_RESP) && (state_q != ST_RESP) && rd_kind) begin
      rdata_d = rd_inr ? mem[rd_idx] : 32'h0;
    end
  end

  // Registered outputs and request latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      inr_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      inr_q   <= inr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Array write commits at the edge ending RESP; contents survive reset
  always_ff @(posedge clk) begin
    if ((state_q == ST_RESP) && wr_q && inr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = resp_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
